wrr_grant_sched: RTL and testbench

Weighted round-robin scheduler that shares one multi-cycle resource (bus or port) among 4 requesters.
- Grants are registered, one-hot, and held until the owner releases, drops its request, or a hold watchdog fires.
- Per-requester weights set how many grants each requester receives per arbitration round.
- Sits upstream of the fixed-priority and round-robin grant logic and replaces the single-cycle arbitration when transactions span multiple cycles.

---
 rtl/wrr_pkg.sv | 33 +++
 rtl/wrr_credit_bank.sv | 45 ++++
 rtl/wrr_grant_sched.sv | 104 ++++++++++
 tb/tb_wrr_grant_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkg.sv
// Shared types, defaults and the circular pick helper for the WRR grant scheduler.
package wrr_pkg;
  localparam int NREQ     = 4;
  localparam int WW       = 3;
  localparam int HOLD_MAX = 15;
  localparam int CW       = 5;   // hold counter width, covers HOLD_MAX up to 31

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;
  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic vld;
    idx_t idx;
  } pick_t;

  // First requester at or after 'start' (circularly) that requests and has credit.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [NREQ-1:0] credit_nz,
                                    input idx_t            start);
    pick_t p;
    idx_t  k;
    p = '0;
    // Walk offsets from far to near so the nearest eligible index wins.
    for (int i = NREQ-1; i >= 0; i--) begin
      k = start + idx_t'(i);
      if (req[k] && credit_nz[k]) begin
        p.vld = 1'b1;
        p.idx = k;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/wrr_credit_bank.sv
// Weight and credit storage: weights are software-written, credits are spent one
// per grant and refilled from the weights when every requester has run dry.
module wrr_credit_bank
  import wrr_pkg::*;
#(
  parameter int WW = wrr_pkg::WW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  idx_t            sel,
  input  logic [WW-1:0]   data,
  input  logic            reload,
  input  logic            dec,
  input  idx_t            dec_idx,
  output logic [NREQ-1:0] credit_nz
);
  localparam logic [NREQ-1:0][WW-1:0] ONES = {NREQ{WW'(1)}};

  logic [NREQ-1:0][WW-1:0] wt_q, wt_d, cr_q, cr_d;

  // Next weights/credits: reload reads the pre-write weights, decrement applies on top.
  always_comb begin
    wt_d = wt_q;
    cr_d = cr_q;
    if (wr) wt_d[sel] = (data == '0) ? WW'(1) : data;
    if (reload) cr_d = wt_q;
    if (dec) cr_d[dec_idx] = cr_d[dec_idx] - WW'(1);
  end

  // Weight and credit registers, all start at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_q <= ONES;
      cr_q <= ONES;
    end else begin
      wt_q <= wt_d;
      cr_q <= cr_d;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_nz
    assign credit_nz[i] = |cr_q[i];
  end
endmodule

// File: rtl/wrr_grant_sched.sv
// Weighted round-robin scheduler for a multi-cycle shared resource: one-hot
// registered grant held until done, request drop, or hold watchdog expiry.
module wrr_grant_sched
  import wrr_pkg::*;
#(
  parameter int WW       = wrr_pkg::WW,
  parameter int HOLD_MAX = wrr_pkg::HOLD_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  input  logic            wt_wr,
  input  idx_t            wt_sel,
  input  logic [WW-1:0]   wt_data,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output idx_t            owner,
  output logic            timeout_evt
);
  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d, to_q, to_d;
  idx_t            owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] credit_nz, elig_nz;
  logic            reload, dec;
  idx_t            start;
  pick_t           pick0, pick;

  wrr_credit_bank #(.WW(WW)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wt_wr),
    .sel      (wt_sel),
    .data     (wt_data),
    .reload   (reload),
    .dec      (dec),
    .dec_idx  (pick.idx),
    .credit_nz(credit_nz)
  );

  // Selection, release decision and next-state for all registered outputs.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    dec     = 1'b0;
    start   = owner_q + idx_t'(1);
    pick0   = rr_pick(req, credit_nz, start);
    // Out of credit everywhere: refill and pick in the same cycle, every weight is >= 1.
    reload  = (state_q == IDLE) && (|req) && !pick0.vld;
    elig_nz = reload ? '1 : credit_nz;
    pick    = rr_pick(req, elig_nz, start);
    case (state_q)
      IDLE: if (pick.vld) begin
        dec     = 1'b1;
        owner_d = pick.idx;
        gnt_d   = NREQ'(1) << pick.idx;
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: if (done[owner_q] || !req[owner_q] || cnt_q == CW'(HOLD_MAX-1)) begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        to_d    = !done[owner_q] && req[owner_q];
        state_d = GAP;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CW'(1);
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= 2'd3;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign timeout_evt = to_q;
endmodule

// File: tb/tb_wrr_grant_sched.sv
// Scoreboard bench for wrr_grant_sched: stimulus pushes expected grant episodes,
// a monitor pops and checks them on every new grant and grant release.
module tb_wrr_grant_sched;
  import wrr_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0, done = '0, gnt;
  logic            wt_wr = 1'b0, busy, timeout_evt;
  idx_t            wt_sel = '0, owner;
  logic [WW-1:0]   wt_data = '0;

  wrr_grant_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .wt_wr(wt_wr), .wt_sel(wt_sel), .wt_data(wt_data),
    .gnt(gnt), .busy(busy), .owner(owner), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // One grant episode: grant value, hold length (0 = any), timeout at release,
  // zero cycles before it (0 = any).
  typedef struct {
    logic [3:0] g;
    int         len;
    bit         to;
    int         gap;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk = 0, n_fail = 0;
  bit   mon_en = 0, active = 0;
  int   len_c = 0, zcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input int len, input bit to, input int gap);
    exp_t e;
    e.g = g; e.len = len; e.to = to; e.gap = gap;
    q.push_back(e);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic wait_grant();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1;
    end
    if (!seen) chk("grant_wait_timeout", 0, 1);
  endtask

  task automatic wait_fall();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (gnt == '0) seen = 1;
    end
    if (!seen) chk("release_wait_timeout", 0, 1);
  endtask

  // Wait for a grant, pulse done on the owner one cycle later.
  task automatic grant_done();
    wait_grant();
    @(negedge clk);
    done = gnt;
    @(negedge clk);
    done = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr_wt(input idx_t s, input logic [WW-1:0] d);
    wt_wr = 1'b1; wt_sel = s; wt_data = d;
    @(negedge clk);
    wt_wr = 1'b0;
  endtask

  initial begin
    fork
      // Monitor: invariants every cycle, episode checks on grant rise and fall.
      forever begin
        @(negedge clk);
        if (mon_en) begin
          chk("onehot0", 32'($onehot0(gnt)), 1);
          chk("busy_eq_gnt", 32'(busy), 32'(gnt != '0));
          if (!active && gnt != '0) begin
            if (q.size() == 0) begin
              chk("unexpected_grant", 32'(gnt), 0);
            end else begin
              cur = q.pop_front();
              chk("grant", 32'(gnt), 32'(cur.g));
              chk("owner", 32'(owner), 32'(idx_of(cur.g)));
              if (cur.gap != 0) chk("gap_len", zcnt, cur.gap);
            end
            active = 1; len_c = 1;
            chk("no_stray_timeout", 32'(timeout_evt), 0);
          end else if (active && gnt != '0) begin
            len_c++;
            chk("no_stray_timeout", 32'(timeout_evt), 0);
          end else if (active) begin
            chk("timeout_at_release", 32'(timeout_evt), 32'(cur.to));
            if (cur.len != 0) chk("hold_len", len_c, cur.len);
            active = 0; zcnt = 1;
          end else begin
            zcnt++;
            chk("no_stray_timeout", 32'(timeout_evt), 0);
          end
        end
      end
    join_none

    // Reset state.
    idle(2);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 3);
    chk("rst_timeout", 32'(timeout_evt), 0);
    rst_n = 1'b1;
    mon_en = 1;

    // Two requesters alternate, credits refill transparently.
    push(4'b0001, 2, 0, 0); push(4'b0100, 2, 0, 2);
    push(4'b0001, 2, 0, 2); push(4'b0100, 2, 0, 2);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) grant_done();
    req = '0;
    idle(4);

    // Weighted: w0=3, w1=0 (acts as 1); refill happens without an idle cycle.
    do_reset();
    wr_wt(2'd0, 3'd3);
    wr_wt(2'd1, 3'd0);
    push(4'b0001, 2, 0, 0);
    push(4'b0010, 2, 0, 2); push(4'b0100, 2, 0, 2); push(4'b1000, 2, 0, 2);
    push(4'b0001, 2, 0, 2); push(4'b0010, 2, 0, 2); push(4'b0100, 2, 0, 2);
    push(4'b1000, 2, 0, 2); push(4'b0001, 2, 0, 2); push(4'b0001, 2, 0, 2);
    push(4'b0010, 2, 0, 2);
    req = 4'b1111;
    for (int k = 0; k < 11; k++) grant_done();
    req = '0;
    idle(4);

    // Watchdog: held 15 cycles, timeout pulse on release, re-granted after the gap.
    do_reset();
    push(4'b0010, 15, 1, 0); push(4'b0010, 15, 1, 2);
    req = 4'b0010;
    wait_grant(); wait_fall();
    wait_grant(); wait_fall();
    req = '0;
    idle(4);

    // Owner abandons in its third hold cycle; next requester follows.
    do_reset();
    push(4'b0010, 3, 0, 0); push(4'b0100, 2, 0, 2);
    req = 4'b0110;
    wait_grant();
    idle(2);
    req = 4'b0100;
    grant_done();
    req = '0;
    idle(4);

    // done coincides with watchdog expiry: normal release.
    do_reset();
    push(4'b0001, 15, 0, 0);
    req = 4'b0001;
    wait_grant();
    idle(14);
    done = 4'b0001;
    @(negedge clk);
    done = '0;
    req = '0;
    idle(4);

    // Async reset in the middle of a hold, then immediate re-grant.
    do_reset();
    push(4'b1000, 0, 0, 0); push(4'b1000, 2, 0, 0);
    req = 4'b1000;
    wait_grant();
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_owner", 32'(owner), 3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_gnt", 32'(gnt), 32'(4'b1000));
    @(negedge clk);
    done = 4'b1000;
    @(negedge clk);
    done = '0;
    req = '0;
    idle(4);

    // Drain.
    for (int i = 0; i < 200 && (q.size() != 0 || active); i++) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
